// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accum_pkg
// Brief    : Shared state encoding and width helper for the frame accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package accum_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_HOLD  = ST_HOLD
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_add_core.sv
`default_nettype none
// ============================================================================
// Module   : accum_add_core
// Brief    : Combinational N-bit unsigned adder with carry in and carry out.
// Revision : 1.0 - initial release
// ============================================================================
module accum_add_core #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] sum_o,
    output logic         co_o
);

    logic [N:0] w_sum;

    assign w_sum = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, ci_i};
    assign sum_o = w_sum[N-1:0];
    assign co_o  = w_sum[N];

endmodule
`default_nettype wire

// File: rtl/accum_nbit_frame.sv
`default_nettype none
// ============================================================================
// Module   : accum_nbit_frame
// Brief    : Sums CNT accepted operands per frame and presents the sum plus a
//            sticky carry flag; define ACCUM_SAT_EN to saturate on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module accum_nbit_frame
    import accum_pkg::*;
#(
    parameter int N   = 8,
    parameter int CNT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_sum_o,
    output logic         out_carry_o
);

    localparam int CNT_W = clog2(CNT + 1);

    state_t             state_q, state_d;
    logic [N-1:0]       acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_accept;
    logic [N-1:0]       w_sum;
    logic               w_co;
    logic [N-1:0]       w_acc_step;

    accum_add_core #(
        .N (N)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (in_data_i),
        .ci_i  (1'b0),
        .sum_o (w_sum),
        .co_o  (w_co)
    );

`ifdef ACCUM_SAT_EN
    assign w_acc_step = w_co ? {N{1'b1}} : w_sum;
`else
    assign w_acc_step = w_sum;
`endif

    // Handshake outputs decode from state only; out_ready never reaches in_ready.
    assign in_ready_o  = (state_q != S_HOLD);
    assign out_valid_o = (state_q == S_HOLD);
    assign out_sum_o   = acc_q;
    assign out_carry_o = carry_q;
    assign w_accept    = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    acc_d   = in_data_i;
                    carry_d = 1'b0;
                    cnt_d   = CNT_W'(1);
                    state_d = (CNT == 1) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    acc_d   = w_acc_step;
                    carry_d = carry_q | w_co;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CNT - 1)) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accum_nbit_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_nbit_frame
// Brief    : Directed self-checking bench for accum_nbit_frame (CNT=4 and CNT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_nbit_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_carry;
    logic [7:0] in_data, out_sum;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_carry1;
    logic [7:0] in_data1, out_sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accum_nbit_frame #(.N(8), .CNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_carry_o (out_carry)
    );

    accum_nbit_frame #(.N(8), .CNT(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid1),
        .in_ready_o  (in_ready1),
        .in_data_i   (in_data1),
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready1),
        .out_sum_o   (out_sum1),
        .out_carry_o (out_carry1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;  in_data = 8'd0;  out_ready = 1'b0;
        in_valid1 = 1'b0; in_data1 = 8'd0; out_ready1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid1", 32'(out_valid1), 32'd0);

        // Scenario 1: back-to-back 10,20,30,40
        out_ready = 1'b1;
        beat(8'd10);
        chk("s1_no_early_valid", 32'(out_valid), 32'd0);
        beat(8'd20);
        beat(8'd30);
        beat(8'd40);
        chk("s1_out_valid", 32'(out_valid), 32'd1);
        chk("s1_in_ready_low", 32'(in_ready), 32'd0);
        chk("s1_sum", 32'(out_sum), 32'd100);
        chk("s1_carry", 32'(out_carry), 32'd0);
        tick();
        chk("s1_valid_one_cycle", 32'(out_valid), 32'd0);
        chk("s1_in_ready_back", 32'(in_ready), 32'd1);

        // Scenario 2: overflow 200,100,0,0
        beat(8'd200);
        beat(8'd100);
        beat(8'd0);
        beat(8'd0);
        chk("s2_out_valid", 32'(out_valid), 32'd1);
`ifdef ACCUM_SAT_EN
        chk("s2_sum", 32'(out_sum), 32'd255);
`else
        chk("s2_sum", 32'(out_sum), 32'd44);
`endif
        chk("s2_carry", 32'(out_carry), 32'd1);
        tick();

        // Scenario 3: backpressure for 5 cycles
        out_ready = 1'b0;
        beat(8'd1);
        beat(8'd1);
        beat(8'd1);
        beat(8'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd99;
            chk("s3_hold_valid", 32'(out_valid), 32'd1);
            chk("s3_hold_in_ready", 32'(in_ready), 32'd0);
            chk("s3_hold_sum", 32'(out_sum), 32'd4);
            chk("s3_hold_carry", 32'(out_carry), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("s3_release_in_ready", 32'(in_ready), 32'd1);
        chk("s3_release_valid", 32'(out_valid), 32'd0);

        // Scenario 4: two idle cycles between beats with junk data
        beat(8'd5);
        for (int b = 0; b < 3; b++) begin
            in_data = 8'hFF;
            tick();
            tick();
            chk("s4_gap_no_valid", 32'(out_valid), 32'd0);
            beat(8'(6 + b));
        end
        chk("s4_out_valid", 32'(out_valid), 32'd1);
        chk("s4_sum", 32'(out_sum), 32'd26);
        chk("s4_carry", 32'(out_carry), 32'd0);
        tick();

        // Scenario 5: reset mid-frame discards partial sum
        beat(8'd50);
        beat(8'd60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_after_rst_valid", 32'(out_valid), 32'd0);
        chk("s5_after_rst_sum", 32'(out_sum), 32'd0);
        beat(8'd1);
        beat(8'd2);
        chk("s5_no_aborted_output", 32'(out_valid), 32'd0);
        beat(8'd3);
        chk("s5_still_no_output", 32'(out_valid), 32'd0);
        beat(8'd4);
        chk("s5_out_valid", 32'(out_valid), 32'd1);
        chk("s5_sum", 32'(out_sum), 32'd10);

        // Reset while holding a result drops it
        out_ready = 1'b0;
        tick();
        chk("s5b_holding", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5b_rst_drops_valid", 32'(out_valid), 32'd0);
        chk("s5b_rst_clears_sum", 32'(out_sum), 32'd0);
        chk("s5b_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Scenario 6: CNT=1 instance, beats 7 then 9
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_data1   = 8'd7;
        tick();
        chk("s6_first_valid", 32'(out_valid1), 32'd1);
        chk("s6_first_sum", 32'(out_sum1), 32'd7);
        chk("s6_first_carry", 32'(out_carry1), 32'd0);
        chk("s6_first_in_ready_low", 32'(in_ready1), 32'd0);
        in_data1 = 8'd9;
        tick();
        chk("s6_emit_valid_low", 32'(out_valid1), 32'd0);
        chk("s6_emit_in_ready", 32'(in_ready1), 32'd1);
        tick();
        in_valid1 = 1'b0;
        chk("s6_second_valid", 32'(out_valid1), 32'd1);
        chk("s6_second_sum", 32'(out_sum1), 32'd9);
        chk("s6_second_carry", 32'(out_carry1), 32'd0);
        chk("s6_second_in_ready_low", 32'(in_ready1), 32'd0);
        tick();
        chk("s6_done_valid", 32'(out_valid1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
